// File: rtl/sseg_scan_ctrl_if.sv
// Display-side bus of the seven-segment scan controller: word load strobe, enable and panel drive.
interface sseg_scan_ctrl_if;
   logic        en;
   logic        load;
   logic [15:0] digits;
   logic [3:0]  dp_en;
   logic        blank_lz;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frame_start;

   modport master (
      output en, load, digits, dp_en, blank_lz,
      input  an, seg, frame_start
   );

   modport slave (
      input  en, load, digits, dp_en, blank_lz,
      output an, seg, frame_start
   );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed 7-seg scanner, double-buffered word, blank gaps, leading-zero blanking.
// Latency: outputs registered, one edge after the state/en they reflect; new words show next frame.
// Backpressure: none; load is a fire-and-forget strobe, last load before a frame boundary wins.
module sseg_scan_ctrl #(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset,
   sseg_scan_ctrl_if.slave  bus
);

   localparam int CMAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] DLAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic {BLANK, ON} state_t;

   typedef struct packed {
      logic        lz;
      logic [3:0]  dp;
      logic [15:0] dig;
   } disp_t;

   disp_t           hold;
   disp_t           shadow;
   state_t          state;
   logic [1:0]      idx;
   logic [CW-1:0]   cnt;
   logic [3:0]      an_q;
   logic [7:0]      seg_q;
   logic            fs_q;

   state_t          nxt_state;
   logic [1:0]      nxt_idx;
   logic [CW-1:0]   nxt_cnt;
   logic            boundary;
   logic [3:0]      zero;
   logic [3:0]      sup;
   logic [3:0]      nib;
   logic [7:0]      seg_on;
   logic [3:0]      an_on;
   logic            lit;

   function automatic logic [7:0] hex_dec(input logic [3:0] v);
      logic [7:0] r;
      case (v)
         4'h0: r = 8'hC0;
         4'h1: r = 8'hF9;
         4'h2: r = 8'hA4;
         4'h3: r = 8'hB0;
         4'h4: r = 8'h99;
         4'h5: r = 8'h92;
         4'h6: r = 8'h82;
         4'h7: r = 8'hF8;
         4'h8: r = 8'h80;
         4'h9: r = 8'h90;
         4'hA: r = 8'h88;
         4'hB: r = 8'h83;
         4'hC: r = 8'hC6;
         4'hD: r = 8'hA1;
         4'hE: r = 8'h86;
         default: r = 8'h8E;
      endcase
      return r;
   endfunction

   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      nxt_cnt   = cnt + 1'b1;
      boundary  = 1'b0;
      if (state == BLANK) begin
         if (cnt == BLAST) begin
            nxt_state = ON;
            nxt_cnt   = '0;
         end
      end else begin
         if (cnt == DLAST) begin
            nxt_state = BLANK;
            nxt_cnt   = '0;
            nxt_idx   = idx + 2'd1;
            boundary  = (idx == 2'd3);
         end
      end
   end

   // A digit is blank-able only if it and every digit to its left are zero with no dp.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         zero[j] = (shadow.dig[4*j +: 4] == 4'h0) && !shadow.dp[j];
      end
      sup = {zero[3],
             zero[3] & zero[2],
             zero[3] & zero[2] & zero[1],
             1'b0} & {4{shadow.lz}};
   end

   // Drive decode looks at the slot being entered so an/seg line up with the state register.
   always_comb begin
      nib    = shadow.dig[{nxt_idx, 2'b00} +: 4];
      seg_on = hex_dec(nib) & ~{shadow.dp[nxt_idx], 7'b0};
      an_on  = ~(4'b0001 << nxt_idx);
      lit    = bus.en && (nxt_state == ON) && !sup[nxt_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold   <= '0;
         shadow <= '0;
         state  <= BLANK;
         idx    <= 2'd0;
         cnt    <= '0;
         an_q   <= 4'hF;
         seg_q  <= 8'hFF;
         fs_q   <= 1'b0;
      end else begin
         state <= nxt_state;
         idx   <= nxt_idx;
         cnt   <= nxt_cnt;
         if (bus.load) begin
            hold <= '{lz: bus.blank_lz, dp: bus.dp_en, dig: bus.digits};
         end
         if (boundary) begin
            shadow <= hold;
         end
         fs_q  <= boundary;
         an_q  <= lit ? an_on  : 4'hF;
         seg_q <= lit ? seg_on : 8'hFF;
      end
   end

   assign bus.an          = an_q;
   assign bus.seg         = seg_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with DIGIT_CYCLES=4, BLANK_CYCLES=2 (24-cycle frames).
module tb_sseg_scan_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   sseg_scan_ctrl_if dif ();

   sseg_scan_ctrl #(
      .DIGIT_CYCLES (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Checks n cycles of one frame starting at its first cycle (p=0), optionally
   // pulsing load at ld_at and holding en low over cycles en_lo..en_hi.
   task automatic frame(input string name, input bit first, input logic [31:0] segs,
                        input logic [3:0] sup, input int n,
                        input int ld_at, input logic [15:0] ld_dig,
                        input logic [3:0] ld_dp, input logic ld_lz,
                        input int en_lo, input int en_hi);
      logic       en_prev;
      logic       en_now;
      logic       on;
      logic [3:0] one;
      logic [3:0] an_exp;
      logic [7:0] seg_exp;
      int         slot;
      int         off;
      en_prev = 1'b1;
      one     = 4'b0001;
      for (int p = 0; p < n; p++) begin
         slot    = p / 6;
         off     = p % 6;
         on      = (off >= 2) && !sup[slot] && en_prev;
         an_exp  = on ? ~(one << slot) : 4'hF;
         seg_exp = on ? segs[slot*8 +: 8] : 8'hFF;
         chk($sformatf("%s p%0d an", name, p), {4'h0, dif.an}, {4'h0, an_exp});
         chk($sformatf("%s p%0d seg", name, p), dif.seg, seg_exp);
         chk($sformatf("%s p%0d frame_start", name, p), {7'h0, dif.frame_start},
             {7'h0, (p == 0) && !first});
         en_now = !(p >= en_lo && p <= en_hi);
         dif.en = en_now;
         en_prev = en_now;
         if (p == ld_at) begin
            dif.load     = 1'b1;
            dif.digits   = ld_dig;
            dif.dp_en    = ld_dp;
            dif.blank_lz = ld_lz;
         end else begin
            dif.load = 1'b0;
         end
         step();
      end
      dif.load = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      dif.en       = 1'b1;
      dif.load     = 1'b0;
      dif.digits   = 16'h0;
      dif.dp_en    = 4'h0;
      dif.blank_lz = 1'b0;
      step();
      step();
      chk("reset an", {4'h0, dif.an}, 8'h0F);
      chk("reset seg", dif.seg, 8'hFF);
      chk("reset frame_start", {7'h0, dif.frame_start}, 8'h00);
      reset = 1'b0;

      frame("f1", 1'b1, 32'hC0C0C0C0, 4'b0000, 24, -1, 16'h0, 4'h0, 1'b0, -1, -1);
      frame("f2", 1'b0, 32'hC0C0C0C0, 4'b0000, 24, 10, 16'h12AF, 4'h0, 1'b0, -1, -1);
      frame("f3", 1'b0, 32'hF9A4888E, 4'b0000, 24, 5, 16'h0050, 4'h0, 1'b1, -1, -1);
      frame("f4", 1'b0, 32'hFFFF92C0, 4'b1100, 24, 5, 16'h0000, 4'h0, 1'b1, -1, -1);
      frame("f5", 1'b0, 32'hFFFFFFC0, 4'b1110, 24, 5, 16'h0000, 4'b0100, 1'b1, -1, -1);
      frame("f6", 1'b0, 32'hFF40C0C0, 4'b1000, 24, 23, 16'h1234, 4'h0, 1'b0, 8, 10);
      frame("f7", 1'b0, 32'hFF40C0C0, 4'b1000, 24, -1, 16'h0, 4'h0, 1'b0, -1, -1);
      frame("f8", 1'b0, 32'hF9A4B099, 4'b0000, 16, 3, 16'hFFFF, 4'hF, 1'b1, -1, -1);

      reset = 1'b1;
      step();
      chk("midreset an", {4'h0, dif.an}, 8'h0F);
      chk("midreset seg", dif.seg, 8'hFF);
      chk("midreset frame_start", {7'h0, dif.frame_start}, 8'h00);
      reset = 1'b0;

      frame("r1", 1'b1, 32'hC0C0C0C0, 4'b0000, 24, -1, 16'h0, 4'h0, 1'b0, -1, -1);
      frame("r2", 1'b0, 32'hC0C0C0C0, 4'b0000, 24, -1, 16'h0, 4'h0, 1'b0, -1, -1);
      chk("r3 frame_start", {7'h0, dif.frame_start}, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Four-digit multiplexed seven-segment scan controller. It shares the single `seg` bus between the four digit anodes. It holds a double-buffered 16-bit display word so that values from the counter datapath never tear mid-frame. It inserts anti-ghosting blank gaps between digit slots and optionally suppresses leading zeros. It replaces the fixed single-digit drive (`an` tied to 4'b1110) in the counter top level.

## Interface
- `DIGIT_CYCLES`, 100000, clocks each digit is lit per slot (≥1).
- `BLANK_CYCLES`, 1000, clocks of all-anodes-off gap before each digit slot (≥1).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  display enable; low forces all anodes off, scanning continues.
- `load`  in  1  one-cycle strobe; captures `digits`, `dp_en`, `blank_lz` into the holding register.
- `digits`  in  16  hex nibbles; `digits[3:0]` is digit 0 (rightmost, `an[0]`).
- `dp_en`  in  4  decimal point request per digit, bit i ↔ digit i.
- `blank_lz`  in  1  leading-zero suppression enable.
- `an`  out  4  anodes, active low, registered.
- `seg`  out  8  cathodes, active low, registered; `seg[0..6]` = a..g, `seg[7]` = dp.
- `frame_start`  out  1  one-cycle pulse, first cycle of each new frame.

## Operation
- Holding register: on any edge with `load`=1, it takes `{blank_lz, dp_en, digits}`. Last load wins. There is no handshake back; the source may load at any rate.
- Shadow register: drives the display and is copied from holding only on the frame-boundary edge. The frame-boundary edge is the last ON cycle of digit 3, transitioning to BLANK of digit 0.
- If `load` and the frame-boundary edge coincide, the shadow gets the old holding value. The new value reaches the shadow one frame later.
- FSM states: BLANK and ON, with digit index `idx` (0..3) and a phase counter.
  - BLANK: `an`=4'b1111, `seg`=8'hFF, lasting BLANK_CYCLES. Then go to ON with the same `idx`.
  - ON: `an[idx]`=0 with the others 1, and `seg` = decode(shadow nibble `idx`) with dp, lasting DIGIT_CYCLES. Then go to BLANK, with `idx`+1 mod 4.
- Frame length is exactly 4·(BLANK_CYCLES+DIGIT_CYCLES) cycles. `idx` wraps 3→0.
- Hex decode, active low, as `seg[7:0]` with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Decimal point: `seg[7]`=0 when shadow dp bit `idx` is 1.
- Leading-zero suppression applies to digit i (i = 1..3) when shadow `blank_lz`=1 and, for every j ≥ i, nibble j = 0 and dp j = 0. A suppressed digit gives `an`=4'b1111 and `seg`=8'hFF during its ON slot, and the slot timing is unchanged. Digit 0 is never suppressed.
- `en`=0 forces `an`=4'b1111 and `seg`=8'hFF on the next edge. FSM, counters and shadow copy proceed normally. Re-enabling resumes in the current slot.

## Timing
- Reset, on an edge with `reset`=1, clears all of the following:
  - holding and shadow contents to 0, so the display shows 0000 with no suppression and no dp;
  - state to BLANK, `idx`=0, counter 0;
  - outputs to `an`=4'b1111, `seg`=8'hFF, `frame_start`=0.
- Reset mid-operation aborts the current slot immediately with the values above. No `frame_start` is issued for the aborted frame.
- After reset release:
  - BLANK of digit 0 runs for BLANK_CYCLES cycles.
  - Then `an`=4'b1110 for DIGIT_CYCLES cycles.
  - The first `frame_start` follows the first digit-3 ON phase.
- `frame_start` is high for exactly the first cycle of digit-0 BLANK. In that cycle the new shadow is already in effect. Pulses are spaced exactly one frame apart.
- All outputs are registered and change only on rising edges. Anodes never overlap, and at least one BLANK cycle of all-off always separates two lit digits.

## Test plan
Parameters: DIGIT_CYCLES=4, BLANK_CYCLES=2, so a frame is 24 cycles.
- Reset, then release → `an`=1111 and `seg`=FF for 2 cycles; `an`=1110 and `seg`=C0 for 4 cycles; 2 blank cycles; `an`=1101 for 4 cycles; then digits 2 and 3 in turn. `frame_start` first pulses 24 cycles after release, then every 24 cycles.
- `load` of `digits`=16'h12AF mid-frame → the current frame is unchanged. The next frame shows digit0 `seg`=8E, digit1 88, digit2 A4, digit3 F9.
- `blank_lz`=1 with `digits`=16'h0050 → digit 0 shows C0 and digit 1 shows 92. The digit 2 and 3 ON slots show `an`=1111 and `seg`=FF, with slot timing unchanged. With 16'h0000, only digit 0 lights (C0).
- `blank_lz`=1, `digits`=0, `dp_en`=4'b0100 → digit 2 shows `seg`=40; digits 0 and 1 show C0; digit 3 is suppressed.
- `load` exactly on the frame-boundary edge → the new value appears only after the next `frame_start` (24 cycles later). `en`=0 for 3 cycles during digit-1 ON → `an`=1111 on those cycles, and slot boundaries do not shift.
- `reset` asserted during digit-2 ON → `an`=1111, `seg`=FF, and shadow cleared on the next edge. After release the scan restarts at digit 0 with a full 2-cycle BLANK.
